// File: rtl/rti_pkg.sv
// rtl/rti_pkg.sv - shared widths, entry field offsets and FSM states for the RTI dispatcher
package rti_pkg;

  localparam int TIME_WIDTH  = 64;
  localparam int DATA_WIDTH  = 64;
  localparam int ENTRY_WIDTH = TIME_WIDTH + DATA_WIDTH;

  // Entry layout: timestamp in the upper field, payload in the lower field
  localparam int TS_MSB   = ENTRY_WIDTH - 1;
  localparam int TS_LSB   = DATA_WIDTH;
  localparam int DATA_MSB = DATA_WIDTH - 1;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } rti_state_t;

endpackage

// File: rtl/rti_time_cmp.sv
// rtl/rti_time_cmp.sv - full-width unsigned equal/late compare of global time against an entry timestamp
module rti_time_cmp #(
  parameter int TIME_WIDTH = rti_pkg::TIME_WIDTH
) (
  input  logic [TIME_WIDTH-1:0] counter,
  input  logic [TIME_WIDTH-1:0] timestamp,
  output logic                  equal,
  output logic                  late
);

  assign equal = (counter == timestamp);
  assign late  = (counter >  timestamp);

endmodule

// File: rtl/rti_timed_dispatcher.sv
// rtl/rti_timed_dispatcher.sv - fetches timestamped entries from the RTI FIFO and releases each
// payload when global time reaches its timestamp, flagging entries that arrive too late
module rti_timed_dispatcher
  import rti_pkg::*;
#(
  parameter int TIME_WIDTH = rti_pkg::TIME_WIDTH,
  parameter int DATA_WIDTH = rti_pkg::DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             enable,
  input  logic [TIME_WIDTH-1:0]            counter,
  input  logic                             fifo_empty,
  input  logic [TIME_WIDTH+DATA_WIDTH-1:0] fifo_dout,
  output logic                             fifo_rd,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             late_error,
  output logic [TIME_WIDTH+DATA_WIDTH-1:0] late_data,
  output logic                             busy,
  output logic [31:0]                      dispatch_count
);

  rti_state_t                       state_q;
  rti_state_t                       state_d;
  logic [TIME_WIDTH+DATA_WIDTH-1:0] entry_q;
  logic [TIME_WIDTH-1:0]            entry_ts;
  logic [DATA_WIDTH-1:0]            entry_payload;
  logic                             ts_equal;
  logic                             ts_late;
  logic                             fetch_ok;
  logic                             do_load;
  logic                             do_fire;
  logic                             do_drop;

  assign entry_ts      = entry_q[TS_MSB:TS_LSB];
  assign entry_payload = entry_q[DATA_MSB:DATA_LSB];

  rti_time_cmp #(
    .TIME_WIDTH (TIME_WIDTH)
  ) u_time_cmp (
    .counter   (counter),
    .timestamp (entry_ts),
    .equal     (ts_equal),
    .late      (ts_late)
  );

  // A fetch is never issued while reset or flush is active, so no entry can slip past a discard
  assign fetch_ok = enable && !fifo_empty && !flush && !reset;

  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    do_load = 1'b0;
    do_fire = 1'b0;
    do_drop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_ok) begin
          fifo_rd = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        do_load = 1'b1;
        state_d = ST_ARMED;
      end
      ST_ARMED: begin
        do_fire = ts_equal;
        do_drop = ts_late;
        // The releasing cycle doubles as the fetch cycle for the next entry
        if (ts_equal || ts_late) begin
          if (fetch_ok) begin
            fifo_rd = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d = ST_IDLE;
      do_load = 1'b0;
      do_fire = 1'b0;
      do_drop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      entry_q        <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      late_error     <= 1'b0;
      late_data      <= '0;
      dispatch_count <= '0;
    end else begin
      state_q    <= state_d;
      out_valid  <= do_fire;
      late_error <= do_drop;
      if (do_load) begin
        entry_q <= fifo_dout;
      end
      if (do_fire) begin
        out_data       <= entry_payload;
        dispatch_count <= dispatch_count + 32'd1;
      end
      if (do_drop) begin
        late_data <= entry_q;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rti_timed_dispatcher.sv
// tb/tb_rti_timed_dispatcher.sv - directed and randomized checks of the timed dispatcher
// against a transaction-level reference model
module tb_rti_timed_dispatcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         enable;
  logic [63:0]  counter;
  logic         fifo_empty;
  logic [127:0] fifo_dout;
  logic         fifo_rd;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         late_error;
  logic [127:0] late_data;
  logic         busy;
  logic [31:0]  dispatch_count;

  always #5 clk = ~clk;

  rti_timed_dispatcher #(
    .TIME_WIDTH (64),
    .DATA_WIDTH (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .enable         (enable),
    .counter        (counter),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
    .fifo_rd        (fifo_rd),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .late_error     (late_error),
    .late_data      (late_data),
    .busy           (busy),
    .dispatch_count (dispatch_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus drive values for the next cycle
  bit           d_reset;
  bit           d_flush;
  bit           d_enable;
  logic [63:0]  d_counter;
  logic [127:0] q[$];
  bit           pop_pending;
  bit           checks_on;

  // Reference model: what the dispatcher holds and what it last reported
  bit           m_loading;
  bit           m_holding;
  logic [127:0] m_entry;
  bit           m_ov;
  logic [63:0]  m_od;
  bit           m_le;
  logic [127:0] m_ld;
  logic [31:0]  m_cnt;

  // Event logs for the directed scenarios
  int           n_rd;
  int           n_ov;
  int           n_le;
  logic [63:0]  ov_ctr[$];
  logic [63:0]  ov_dat[$];

  task automatic clear_logs();
    n_rd = 0;
    n_ov = 0;
    n_le = 0;
    ov_ctr.delete();
    ov_dat.delete();
  endtask

  task automatic cycle();
    bit          idle;
    bit          exp_rd;
    logic [63:0] ts;
    @(negedge clk);
    if (checks_on) begin
      expect_eq("out_valid", out_valid, m_ov);
      expect_eq("late_error", late_error, m_le);
      expect_eq("out_data", out_data, m_od);
      expect_eq("late_data", late_data, m_ld);
      expect_eq("dispatch_count", dispatch_count, m_cnt);
      expect_eq("pulse_exclusive", out_valid & late_error, 0);
    end
    if (out_valid === 1'b1) begin
      n_ov++;
      ov_ctr.push_back(d_counter);
      ov_dat.push_back(out_data);
    end
    if (late_error === 1'b1) n_le++;

    reset   = d_reset;
    flush   = d_flush;
    enable  = d_enable;
    counter = d_counter;
    if (pop_pending) begin
      if (q.size() > 0) fifo_dout = q.pop_front();
      pop_pending = 0;
    end
    fifo_empty = (q.size() == 0);
    #1;

    ts     = m_entry[127:64];
    idle   = !m_loading && !m_holding;
    exp_rd = !d_reset && !d_flush && d_enable && !fifo_empty &&
             (idle || (m_holding && d_counter >= ts));
    if (checks_on) begin
      expect_eq("fifo_rd", fifo_rd, exp_rd);
      expect_eq("busy", busy, !idle);
      expect_eq("rd_while_empty", fifo_rd & fifo_empty, 0);
    end
    if (fifo_rd === 1'b1) begin
      n_rd++;
      pop_pending = 1;
    end

    if (d_reset) begin
      m_loading = 0;
      m_holding = 0;
      m_entry   = '0;
      m_ov      = 0;
      m_od      = '0;
      m_le      = 0;
      m_ld      = '0;
      m_cnt     = '0;
    end else begin
      m_ov = 0;
      m_le = 0;
      if (d_flush) begin
        m_loading = 0;
        m_holding = 0;
      end else if (m_loading) begin
        m_entry   = fifo_dout;
        m_loading = 0;
        m_holding = 1;
      end else if (m_holding) begin
        if (d_counter == ts) begin
          m_ov      = 1;
          m_od      = m_entry[63:0];
          m_cnt     = m_cnt + 1;
          m_holding = 0;
        end else if (d_counter > ts) begin
          m_le      = 1;
          m_ld      = m_entry;
          m_holding = 0;
        end
        if (!m_holding && exp_rd) m_loading = 1;
      end else if (exp_rd) begin
        m_loading = 1;
      end
    end
  endtask

  task automatic reset_dut();
    d_reset = 1;
    d_flush = 0;
    q.delete();
    pop_pending = 0;
    cycle();
    checks_on = 1;
    cycle();
    d_reset = 0;
    clear_logs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;
    reset      = 1'b1;
    flush      = 1'b0;
    enable     = 1'b0;
    counter    = '0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    d_enable   = 0;
    d_counter  = '0;
    checks_on  = 0;
    m_loading  = 0;
    m_holding  = 0;
    m_entry    = '0;
    m_ov       = 0;
    m_od       = '0;
    m_le       = 0;
    m_ld       = '0;
    m_cnt      = '0;
    clear_logs();

    // Reset state
    reset_dut();
    cycle();
    expect_eq("reset_busy", busy, 0);
    expect_eq("reset_out_data", out_data, 0);
    expect_eq("reset_late_data", late_data, 0);
    expect_eq("reset_count", dispatch_count, 0);

    // Single on-time dispatch with counter ramping from 90
    reset_dut();
    q.push_back({64'd100, 64'hAA});
    d_enable = 1;
    for (int c = 90; c <= 105; c++) begin
      d_counter = 64'(c);
      cycle();
    end
    expect_eq("t1_rd_count", n_rd, 1);
    expect_eq("t1_ov_count", n_ov, 1);
    if (n_ov > 0) expect_eq("t1_ov_counter", ov_ctr[0], 101);
    expect_eq("t1_out_data", out_data, 64'hAA);
    expect_eq("t1_count", dispatch_count, 1);

    // Late entry
    reset_dut();
    q.push_back({64'd50, 64'h1});
    d_enable  = 1;
    d_counter = 64'd80;
    for (int i = 0; i < 6; i++) cycle();
    expect_eq("t2_le_count", n_le, 1);
    expect_eq("t2_ov_count", n_ov, 0);
    expect_eq("t2_late_data", late_data, {64'd50, 64'h1});
    expect_eq("t2_count", dispatch_count, 0);

    // Back-to-back entries, counter advancing every two clocks
    reset_dut();
    d_enable = 1;
    for (int k = 0; k < 40; k++) begin
      if (k == 19) begin
        q.push_back({64'd10, 64'h10});
        q.push_back({64'd11, 64'h11});
        q.push_back({64'd12, 64'h12});
      end
      d_counter = 64'(k / 2);
      cycle();
    end
    expect_eq("t3_ov_count", n_ov, 3);
    expect_eq("t3_le_count", n_le, 0);
    for (int i = 0; i < 3; i++) begin
      if (i < ov_ctr.size()) begin
        expect_eq("t3_ov_counter", ov_ctr[i], 64'(11 + i));
        expect_eq("t3_ov_data", ov_dat[i], 64'(16 + i));
      end
    end
    expect_eq("t3_count", dispatch_count, 3);

    // Flush of an armed entry
    reset_dut();
    q.push_back({64'd1000, 64'h55});
    d_enable = 1;
    for (int c = 490; c <= 1010; c++) begin
      d_counter = 64'(c);
      d_flush   = (c == 500);
      cycle();
      if (c == 501) expect_eq("t4_busy_after_flush", busy, 0);
    end
    d_flush = 0;
    expect_eq("t4_ov_count", n_ov, 0);
    expect_eq("t4_le_count", n_le, 0);
    expect_eq("t4_count", dispatch_count, 0);

    // Enable low blocks fetching but not the armed entry
    reset_dut();
    q.push_back({64'd20, 64'h77});
    d_enable  = 1;
    d_counter = 64'd10;
    for (int i = 0; i < 3; i++) cycle();
    d_enable = 0;
    q.push_back({64'd25, 64'h88});
    for (int c = 11; c <= 30; c++) begin
      d_counter = 64'(c);
      cycle();
    end
    expect_eq("t5_rd_count", n_rd, 1);
    expect_eq("t5_ov_count", n_ov, 1);
    expect_eq("t5_out_data", out_data, 64'h77);
    expect_eq("t5_fifo_left", q.size(), 1);

    // Reset while armed, starting from non-zero held outputs
    q.delete();
    clear_logs();
    q.push_back({64'd300, 64'h99});
    d_enable  = 1;
    d_counter = 64'd290;
    for (int i = 0; i < 3; i++) cycle();
    for (int c = 291; c <= 310; c++) begin
      d_counter = 64'(c);
      d_reset   = (c == 295);
      cycle();
      if (c == 296) begin
        expect_eq("t6_out_data_zero", out_data, 0);
        expect_eq("t6_count_zero", dispatch_count, 0);
        expect_eq("t6_busy_zero", busy, 0);
      end
    end
    d_reset = 0;
    expect_eq("t6_ov_count", n_ov, 0);
    expect_eq("t6_le_count", n_le, 0);

    // Randomized traffic
    reset_dut();
    d_counter = 64'd100;
    for (int i = 0; i < 3000; i++) begin
      d_counter = d_counter + 64'($urandom_range(0, 2));
      if (q.size() < 4 && $urandom_range(0, 2) == 0) begin
        e[127:64] = d_counter + 64'($urandom_range(0, 15)) - 64'd4;
        e[63:0]   = {$urandom, $urandom};
        q.push_back(e);
      end
      d_enable = ($urandom_range(0, 7) != 0);
      d_flush  = ($urandom_range(0, 59) == 0);
      d_reset  = ($urandom_range(0, 199) == 0);
      cycle();
    end
    d_flush = 0;
    d_reset = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
